// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b opcode and ALU operation types
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;

endpackage

// File: rtl/control.sv
// rtl/control.sv - LC-3b multicycle Moore control unit (fetch/decode/execute)
module control
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  lc3b_opcode  opcode,
    input  logic        branch_enable,
    input  logic        mem_resp,
    output logic        load_pc,
    output logic        load_cc,
    output logic        load_ir,
    output logic        load_mar,
    output logic        load_mdr,
    output logic        load_regfile,
    output logic        pcmux_sel,
    output logic        storemux_sel,
    output logic        alumux_sel,
    output logic        marmux_sel,
    output logic        mdrmux_sel,
    output logic        regfilemux_sel,
    output lc3b_aluop   aluop,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable
);

    localparam logic [3:0] S_FETCH1    = 4'd0;
    localparam logic [3:0] S_FETCH2    = 4'd1;
    localparam logic [3:0] S_FETCH3    = 4'd2;
    localparam logic [3:0] S_DECODE    = 4'd3;
    localparam logic [3:0] S_ADD       = 4'd4;
    localparam logic [3:0] S_AND       = 4'd5;
    localparam logic [3:0] S_NOT       = 4'd6;
    localparam logic [3:0] S_BR        = 4'd7;
    localparam logic [3:0] S_BR_TAKEN  = 4'd8;
    localparam logic [3:0] S_CALC_ADDR = 4'd9;
    localparam logic [3:0] S_LDR1      = 4'd10;
    localparam logic [3:0] S_LDR2      = 4'd11;
    localparam logic [3:0] S_STR1      = 4'd12;
    localparam logic [3:0] S_STR2      = 4'd13;

    logic [3:0] r_state;
    logic [3:0] w_next_state;

    // State register; reset wins over any in-flight memory wait
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH1;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; mem_resp only matters in the three wait states
    always_comb begin
        w_next_state = S_FETCH1;
        case (r_state)
            S_FETCH1:    w_next_state = S_FETCH2;
            S_FETCH2:    w_next_state = mem_resp ? S_FETCH3 : S_FETCH2;
            S_FETCH3:    w_next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    op_add:         w_next_state = S_ADD;
                    op_and:         w_next_state = S_AND;
                    op_not:         w_next_state = S_NOT;
                    op_br:          w_next_state = S_BR;
                    op_ldr, op_str: w_next_state = S_CALC_ADDR;
                    default:        w_next_state = S_FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT: w_next_state = S_FETCH1;
            S_BR:        w_next_state = branch_enable ? S_BR_TAKEN : S_FETCH1;
            S_BR_TAKEN:  w_next_state = S_FETCH1;
            S_CALC_ADDR: begin
                if (opcode == op_ldr) begin
                    w_next_state = S_LDR1;
                end else if (opcode == op_str) begin
                    w_next_state = S_STR1;
                end else begin
                    w_next_state = S_FETCH1;
                end
            end
            S_LDR1:      w_next_state = mem_resp ? S_LDR2 : S_LDR1;
            S_LDR2:      w_next_state = S_FETCH1;
            S_STR1:      w_next_state = S_STR2;
            S_STR2:      w_next_state = mem_resp ? S_FETCH1 : S_STR2;
            default:     w_next_state = S_FETCH1;
        endcase
    end

    // Moore outputs: defaults first, each state overrides only its own controls
    always_comb begin
        load_pc         = 1'b0;
        load_cc         = 1'b0;
        load_ir         = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_regfile    = 1'b0;
        pcmux_sel       = 1'b0;
        storemux_sel    = 1'b0;
        alumux_sel      = 1'b0;
        marmux_sel      = 1'b0;
        mdrmux_sel      = 1'b0;
        regfilemux_sel  = 1'b0;
        aluop           = alu_add;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b11;
        case (r_state)
            S_FETCH1: begin
                marmux_sel = 1'b1;
                load_mar   = 1'b1;
                load_pc    = 1'b1;
            end
            S_FETCH2, S_LDR1: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = 1'b1;
            end
            S_FETCH3: load_ir = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                aluop        = (r_state == S_AND) ? alu_and :
                               (r_state == S_NOT) ? alu_not : alu_add;
                load_regfile = 1'b1;
                load_cc      = 1'b1;
            end
            S_BR_TAKEN: begin
                pcmux_sel = 1'b1;
                load_pc   = 1'b1;
            end
            S_CALC_ADDR: begin
                alumux_sel = 1'b1;
                load_mar   = 1'b1;
            end
            S_LDR2: begin
                regfilemux_sel = 1'b1;
                load_regfile   = 1'b1;
                load_cc        = 1'b1;
            end
            S_STR1: begin
                storemux_sel = 1'b1;
                aluop        = alu_pass;
                load_mdr     = 1'b1;
            end
            S_STR2: mem_write = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/control.md
# control

Multicycle control unit for the LC-3b datapath. Sits directly upstream of `datapath`. It reads the decoded `opcode`, `branch_enable` and the memory handshake, and steps a Moore state machine through fetch, decode and execute. It drives every mux select, load enable and `aluop` the datapath consumes, plus the memory read/write strobes.

## Interface
No parameters.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  lc3b_opcode (4)  instruction opcode from the datapath IR
- branch_enable  in  1  NZP match of IR[11:9] against the CC register
- mem_resp  in  1  memory completion; one-cycle pulse ends the current access
- load_pc, load_cc, load_ir, load_mar, load_mdr, load_regfile  out  1 each  datapath register load enables
- pcmux_sel  out  1  0 = PC+2, 1 = branch-adder result
- storemux_sel  out  1  regfile port-A index: 0 = IR[8:6], 1 = IR[11:9]
- alumux_sel  out  1  ALU B operand: 0 = SR2 register, 1 = sign-extended offset6 << 1
- marmux_sel  out  1  0 = ALU result, 1 = PC
- mdrmux_sel  out  1  0 = ALU result, 1 = mem_rdata
- regfilemux_sel  out  1  0 = ALU result, 1 = MDR
- aluop  out  lc3b_aluop  ALU operation
- mem_read  out  1  read request, held until mem_resp
- mem_write  out  1  write request, held until mem_resp
- mem_byte_enable  out  2  constant 2'b11 (word accesses only)

## Operation
- Default for all outputs in every state: all outputs 0, aluop = alu_add, mem_byte_enable = 2'b11. Each state overrides only what is listed below.
- fetch1: marmux_sel=1, load_mar, pcmux_sel=0, load_pc. Next state is fetch2.
- fetch2: mem_read, mdrmux_sel=1, load_mdr. Stays in fetch2 while mem_resp=0. Goes to fetch3 on mem_resp=1.
- fetch3: load_ir. Next state is decode.
- decode: no outputs asserted. Next state by opcode:
  - op_add → s_add
  - op_and → s_and
  - op_not → s_not
  - op_br → br
  - op_ldr, op_str → calc_addr
  - any other opcode → fetch1 (executes as a NOP)
- s_add / s_and / s_not: aluop = alu_add / alu_and / alu_not, alumux_sel=0, regfilemux_sel=0, load_regfile, load_cc. Next state is fetch1.
- br: no outputs asserted. Goes to br_taken if branch_enable=1, otherwise to fetch1.
- br_taken: pcmux_sel=1, load_pc. Next state is fetch1.
- calc_addr: storemux_sel=0, alumux_sel=1, aluop=alu_add, marmux_sel=0, load_mar. Goes to ldr1 when opcode=op_ldr, to str1 when opcode=op_str.
- ldr1: mem_read, mdrmux_sel=1, load_mdr. Stays in ldr1 until mem_resp=1, then goes to ldr2.
- ldr2: regfilemux_sel=1, load_regfile, load_cc. Next state is fetch1.
- str1: storemux_sel=1, aluop=alu_pass, mdrmux_sel=0, load_mdr. Next state is str2.
- str2: mem_write. Stays in str2 until mem_resp=1, then goes to fetch1.

## Timing
- Outputs are purely combinational functions of the current state (Moore); no input reaches an output combinationally.
- Reset: rst high at a rising edge forces state to fetch1, regardless of the current state or any in-flight memory access. After reset the outputs therefore equal the fetch1 values: load_mar=1, marmux_sel=1, load_pc=1, everything else default.
- A memory request is dropped on the edge that leaves the wait state. mem_resp arriving in any state other than fetch2, ldr1 or str2 is ignored.
- Cycle counts with single-cycle memory (mem_resp high in the first wait cycle):
  - ADD/AND/NOT: 5 cycles
  - BR not taken: 5; BR taken: 6
  - LDR: 7; STR: 7
- Each extra mem_resp-low cycle in a wait state adds one cycle.
- opcode and branch_enable are sampled only in decode, br and calc_addr. They are stable from IR, which loads only in fetch3.

## Structure
- Package `lc3b_types` owns `lc3b_opcode` (op_add, op_and, op_br, op_ldr, op_not, op_str, …) and `lc3b_aluop` (alu_add, alu_and, alu_not, alu_pass, …). This block adds nothing to the package.
- The state enum is local to `control`.
- Single module with no sub-modules: one state register, one next-state block, one output block.

## Test plan
- Reset: assert rst in str2 with mem_resp=0. Next cycle: state is fetch1, mem_write=0, load_mar=1, marmux_sel=1, load_pc=1.
- ADD with mem_resp=1 in the first fetch2 cycle: the sequence is fetch1, fetch2, fetch3, decode, s_add. s_add asserts load_regfile=1, load_cc=1, aluop=alu_add; the next cycle is back in fetch1.
- Memory stall: hold mem_resp=0 for 3 cycles in fetch2. mem_read and load_mdr stay high for 4 cycles total, and load_ir pulses exactly once, the cycle after mem_resp.
- BR: with branch_enable=1, br_taken asserts pcmux_sel=1 and load_pc=1 for one cycle. With branch_enable=0, br goes straight to fetch1 with load_pc never asserted after fetch1.
- LDR then STR: LDR gives calc_addr (alumux_sel=1, load_mar) → ldr1 (mem_read until mem_resp) → ldr2 (regfilemux_sel=1, load_regfile). STR gives str1 (storemux_sel=1, aluop=alu_pass) → str2 (mem_write until mem_resp, mem_read=0 throughout).
- Undefined opcode (e.g. op_trap): decode goes directly to fetch1, with no load_regfile, load_cc or mem_write asserted.
